// File: rtl/fb_pkg.sv
// Shared framebuffer constants, the arbiter state encoding and an address
// range helper used by the arbiter and its bus interface.
package fb_pkg;

    localparam int PIX_W     = 12;                    // 4:4:4 RGB
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;  // 76800
    localparam int ADDR_W    = 17;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        FLUSH,
        RUN
    } state_t;

    // True when the word address lies inside the visible frame.
    function automatic logic in_frame(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(FB_PIXELS);
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Host-writer and framebuffer-RAM bus of the arbiter.
//   slave  : arbiter side (takes host writes, drives the RAM port)
//   master : environment side (host writer + RAM)
interface vga_fb_arbiter_if;
    import fb_pkg::*;

    logic              i_wr_valid;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [PIX_W-1:0]  i_wr_data;
    logic              o_wr_ready;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_we;
    logic [PIX_W-1:0]  o_mem_wdata;
    logic [PIX_W-1:0]  i_mem_rdata;

    modport slave (
        input  i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
        output o_wr_ready, o_mem_addr, o_mem_we, o_mem_wdata
    );

    modport master (
        output i_wr_valid, i_wr_addr, i_wr_data, i_mem_rdata,
        input  o_wr_ready, o_mem_addr, o_mem_we, o_mem_wdata
    );

endinterface

// File: rtl/pix_fifo.sv
// Prefetch pixel FIFO with registered read data.
//   clk, rst_n      : clock, async active-low reset
//   flush           : synchronous clear; wins over push and pop
//   push, push_data : write one entry (caller guarantees space)
//   pop             : read one entry; ignored when empty
//   level, empty    : current occupancy
//   out_data/valid  : popped entry, one cycle after pop; zero otherwise
module pix_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       empty,
    output logic [W-1:0]               out_data,
    output logic                       out_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop_ok;

    // No bypass: a pop only sees entries present at the start of the cycle.
    assign empty  = (level == '0);
    assign pop_ok = pop && !empty;

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                out_data  <= mem[rd_ptr];
                out_valid <= 1'b1;
                rd_ptr    <= rd_ptr + 1'b1;
            end else begin
                out_data  <= '0;
                out_valid <= 1'b0;
            end
            level <= level + LW'(push) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: shares a single-port synchronous RAM between
// display prefetch (into pix_fifo) and a host pixel writer.
//   clk50MHz, i_rst_n : clock, async active-low reset
//   i_frame_start     : frame start pulse; flushes and restarts prefetch
//   i_pix_req         : pop strobe from the VGA driver
//   o_pix_data/valid  : popped pixel, 1 cycle after i_pix_req
//   o_underflow       : sticky, pop on empty FIFO; cleared by a frame start
//   bus               : host write handshake + RAM port
module vga_fb_arbiter
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WATER  = 4
) (
    input  logic             clk50MHz,
    input  logic             i_rst_n,
    input  logic             i_frame_start,
    input  logic             i_pix_req,
    output logic [PIX_W-1:0] o_pix_data,
    output logic             o_pix_valid,
    output logic             o_underflow,
    vga_fb_arbiter_if.slave  bus
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic              inflight;
    logic [LW-1:0]     level, occ;
    logic              fifo_empty, flush, push, pop_req;
    logic              fetch_ok, urgent, issue, grant;

    always_ff @(posedge clk50MHz or negedge i_rst_n) begin
        if (!i_rst_n) state <= WAIT_FRAME;
        else          state <= state_nxt;
    end

    // The frame-start cycle and the FLUSH cycle both act as flush: no
    // fetch, no pops, and any read still in flight is dropped on return.
    always_comb begin
        state_nxt = state;
        flush     = 1'b0;
        occ       = '0;
        fetch_ok  = 1'b0;
        urgent    = 1'b0;
        issue     = 1'b0;
        grant     = 1'b0;
        case (state)
            FLUSH:   state_nxt = RUN;
            default: ;
        endcase
        if (i_frame_start) state_nxt = FLUSH;
        flush = i_frame_start || (state == FLUSH);

        // In-flight read already owns a FIFO slot, so it counts as occupancy.
        occ      = level + LW'(inflight);
        fetch_ok = in_frame(rd_addr) && (occ < LW'(FIFO_DEPTH));
        urgent   = (occ <= LW'(LOW_WATER));
        issue    = i_rst_n && (state == RUN) && !flush && fetch_ok
                   && (urgent || !bus.i_wr_valid);
        // Reset gating keeps the combinational outputs at 0 during reset.
        grant    = i_rst_n && bus.i_wr_valid && !issue;
    end

    always_comb begin
        bus.o_wr_ready  = grant;
        bus.o_mem_we    = grant && in_frame(bus.i_wr_addr);
        bus.o_mem_addr  = issue ? rd_addr : (grant ? bus.i_wr_addr : '0);
        bus.o_mem_wdata = grant ? bus.i_wr_data : '0;
    end

    assign push    = inflight && !flush;
    assign pop_req = i_pix_req && !flush;

    always_ff @(posedge clk50MHz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_addr     <= '0;
            inflight    <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            inflight <= issue;
            if (flush)      rd_addr <= '0;
            else if (issue) rd_addr <= rd_addr + 1'b1;
            if (flush)                      o_underflow <= 1'b0;
            else if (pop_req && fifo_empty) o_underflow <= 1'b1;
        end
    end

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PIX_W)
    ) u_fifo (
        .clk       (clk50MHz),
        .rst_n     (i_rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (bus.i_mem_rdata),
        .pop       (pop_req),
        .level     (level),
        .empty     (fifo_empty),
        .out_data  (o_pix_data),
        .out_valid (o_pix_valid)
    );

endmodule
